led_matrix_scanner: RTL and testbench
=====================================

LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 SHALL have parameter ROW_HOLD, default 1024: clock cycles each row is driven (>=1).
REQ-002 SHALL have parameter BLANK_CYCLES, default 16: clock cycles of all-off before each row (>=1; used only with blanking compiled in).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port enable  input  1  scanning permitted when 1.
REQ-006 SHALL have port redpixels  input  [15:0][15:0]  board red image; [r][c] = row r, column c.
REQ-007 SHALL have port grnpixels  input  [15:0][15:0]  board green image, same indexing.
REQ-008 SHALL have port row_sel  output  [15:0]  one-hot active-high row select, or all-zero.
REQ-009 SHALL have port red_drv  output  [15:0]  red column drivers for the selected row.
REQ-010 SHALL have port grn_drv  output  [15:0]  green column drivers for the selected row.
REQ-011 SHALL have port row_idx  output  4  index of the current row.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse marking the start of a frame.

Function
REQ-013 SHALL implement three states: IDLE, BLANK, DRIVE. All outputs SHALL be registered.
REQ-014 IDLE: row_sel, red_drv, grn_drv = 0; row_idx = 0; with enable=1, the next state SHALL be BLANK with row_idx 0.
REQ-015 Each entry into row 0 (from IDLE or by wrap) SHALL latch redpixels/grnpixels into shadow registers on that same edge; frame_start SHALL be 1 for exactly the first cycle of that row.
REQ-016 BLANK: row_sel, red_drv, grn_drv = 0 for BLANK_CYCLES cycles, then DRIVE.
REQ-017 DRIVE: row_sel = 1<<row_idx; red_drv = shadow_red[row_idx]; grn_drv = shadow_grn[row_idx]; held for ROW_HOLD cycles.
REQ-018 At the end of DRIVE: row_idx SHALL increment; 15 SHALL wrap to 0 (triggering REQ-015); the next state SHALL be BLANK.
REQ-019 Input image changes mid-frame SHALL NOT affect outputs until the next frame latch.
REQ-020 enable=0 in any state SHALL force IDLE on the next edge: outputs 0, row_idx 0, duty counter 0.
REQ-021 Re-enable SHALL always restart at row 0 with a fresh latch and a frame_start pulse.
REQ-022 The duty counter SHALL be sized to max(ROW_HOLD, BLANK_CYCLES) and reset to 0 on every state change.
REQ-023 row_sel SHALL never have more than one bit set; red_drv/grn_drv SHALL be 0 whenever row_sel=0.
REQ-024 Frame period SHALL be 16*(ROW_HOLD+BLANK_CYCLES) cycles with blanking compiled in, and 16*ROW_HOLD without.

Reset
REQ-025 reset=0 at a clock edge SHALL force IDLE with row_sel=0, red_drv=0, grn_drv=0, row_idx=0, frame_start=0, duty counter=0, and shadow registers=0, overriding enable.
REQ-026 Reset asserted mid-frame SHALL take effect on the same edge; after release, scanning SHALL restart per REQ-014.

Configuration
REQ-027 Macro LED_SCAN_BLANK_EN defined: BLANK state present per REQ-016 (anti-ghosting gap).
REQ-028 Macro LED_SCAN_BLANK_EN undefined: BLANK state omitted; IDLE and end-of-DRIVE go directly to DRIVE of the next row; frame_start marks the first DRIVE cycle of row 0; BLANK_CYCLES ignored.

Verification (ROW_HOLD=4, BLANK_CYCLES=2, blanking in unless noted)
REQ-029 reset=0 for 2 cycles with enable=1 -> row_sel=0, red_drv=0, grn_drv=0, row_idx=0, frame_start=0 throughout.
REQ-030 release reset, enable=1, redpixels[0]=16'h0001, grnpixels[0]=16'h8000 -> frame_start high for 1 cycle; row_sel=0 for 2 cycles; then row_sel=16'h0001, red_drv=16'h0001, grn_drv=16'h8000 for 4 cycles.
REQ-031 change redpixels[5] to 16'hFFFF during row 2 -> row 5 shows the old value this frame and 16'hFFFF in the next frame; frame_start pulses are 96 cycles apart.
REQ-032 run through row 15 -> row 15 drive, 2 blank cycles, row_idx returns to 0, and frame_start re-pulses.
REQ-033 enable=0 during row 7 DRIVE -> all outputs 0 next cycle; enable=1 again -> restart at row 0 with frame_start; the same test with reset=0 mid-row gives the same result.
REQ-034 LED_SCAN_BLANK_EN undefined -> row_sel steps 16'h0001, 16'h0002, ... every 4 cycles with no zero gap; frame period 64 cycles.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
//   Scans a 16x16 red/green LED board one row at a time. Both images are
//   latched into shadow registers at the start of every frame, so changes to
//   the input images mid-frame only show up in the following frame.
//
//   Optional feature: define LED_SCAN_BLANK_EN to insert BLANK_CYCLES of
//   all-off before every row (anti-ghosting gap). Without it, rows are driven
//   back to back and BLANK_CYCLES only contributes to the counter width.
//
// Parameters
//   ROW_HOLD      cycles each row is driven (>= 1)
//   BLANK_CYCLES  all-off cycles before each row (>= 1, blanking builds only)
// Ports
//   clk          system clock, posedge
//   reset        synchronous, active-low reset
//   enable       scanning permitted when 1; 0 forces IDLE
//   redpixels    red image, [r][c] = row r, column c
//   grnpixels    green image, same indexing
//   row_sel      one-hot row select, or all-zero
//   red_drv      red column drivers for the selected row
//   grn_drv      green column drivers for the selected row
//   row_idx      current row index
//   frame_start  one-cycle pulse on the first cycle of row 0
module led_matrix_scanner #(
    parameter int unsigned ROW_HOLD     = 1024,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [15:0][15:0] redpixels,
    input  logic [15:0][15:0] grnpixels,
    output logic [15:0]       row_sel,
    output logic [15:0]       red_drv,
    output logic [15:0]       grn_drv,
    output logic [3:0]        row_idx,
    output logic              frame_start
);

    localparam int unsigned CNT_MAX = (ROW_HOLD > BLANK_CYCLES) ? ROW_HOLD : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(ROW_HOLD - 1);
`ifdef LED_SCAN_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        row_idx_q, row_idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0][15:0] shadow_red_q, shadow_red_d;
    logic [15:0][15:0] shadow_grn_q, shadow_grn_d;
    logic [15:0]       row_sel_q, row_sel_d;
    logic [15:0]       red_drv_q, red_drv_d;
    logic [15:0]       grn_drv_q, grn_drv_d;
    logic              frame_start_q, frame_start_d;
    logic              latch;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            row_idx_q     <= '0;
            cnt_q         <= '0;
            shadow_red_q  <= '0;
            shadow_grn_q  <= '0;
            row_sel_q     <= '0;
            red_drv_q     <= '0;
            grn_drv_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_idx_q     <= row_idx_d;
            cnt_q         <= cnt_d;
            shadow_red_q  <= shadow_red_d;
            shadow_grn_q  <= shadow_grn_d;
            row_sel_q     <= row_sel_d;
            red_drv_q     <= red_drv_d;
            grn_drv_q     <= grn_drv_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Next-state logic; latch marks every edge that enters row 0
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        cnt_d     = cnt_q + CNT_W'(1);
        latch     = 1'b0;
        if (!enable) begin
            state_d   = IDLE;
            row_idx_d = '0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    row_idx_d = '0;
                    cnt_d     = '0;
                    latch     = 1'b1;
`ifdef LED_SCAN_BLANK_EN
                    state_d   = BLANK;
`else
                    state_d   = DRIVE;
`endif
                end
`ifdef LED_SCAN_BLANK_EN
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                    end
                end
`endif
                DRIVE: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d     = '0;
                        row_idx_d = row_idx_q + 4'd1;
                        latch     = (row_idx_q == 4'd15);
`ifdef LED_SCAN_BLANK_EN
                        state_d   = BLANK;
`else
                        state_d   = DRIVE;
`endif
                    end
                end
                default: begin
                    state_d   = IDLE;
                    row_idx_d = '0;
                    cnt_d     = '0;
                end
            endcase
        end
    end

    // Output logic. Outputs are registered, so they are computed from the
    // next state; row 0 reads the freshly latched image on the latch edge so
    // the no-blanking build can drive row 0 straight out of IDLE or a wrap.
    always_comb begin
        shadow_red_d  = latch ? redpixels : shadow_red_q;
        shadow_grn_d  = latch ? grnpixels : shadow_grn_q;
        frame_start_d = latch;
        row_sel_d     = '0;
        red_drv_d     = '0;
        grn_drv_d     = '0;
        if (state_d == DRIVE) begin
            row_sel_d = 16'd1 << row_idx_d;
            red_drv_d = shadow_red_d[row_idx_d];
            grn_drv_d = shadow_grn_d[row_idx_d];
        end
    end

    assign row_sel     = row_sel_q;
    assign red_drv     = red_drv_q;
    assign grn_drv     = grn_drv_q;
    assign row_idx     = row_idx_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Testbench for led_matrix_scanner (ROW_HOLD=4, BLANK_CYCLES=2). Adapts to
// LED_SCAN_BLANK_EN. The reference model works from the position inside the
// frame: slot = ROW_HOLD + blank gap, row = pos / slot, phase = pos % slot.
module tb_led_matrix_scanner;

    localparam int HOLD = 4;
    localparam int BLK  = 2;
`ifdef LED_SCAN_BLANK_EN
    localparam int GAP = BLK;
`else
    localparam int GAP = 0;
`endif
    localparam int SLOT   = HOLD + GAP;
    localparam int PERIOD = 16 * SLOT;

    typedef struct packed {
        logic [15:0] rs;
        logic [15:0] rd;
        logic [15:0] gd;
        logic [3:0]  ri;
        logic        fs;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [15:0][15:0] red_img;
    logic [15:0][15:0] grn_img;
    logic [15:0]       row_sel;
    logic [15:0]       red_drv;
    logic [15:0]       grn_drv;
    logic [3:0]        row_idx;
    logic              frame_start;

    led_matrix_scanner #(
        .ROW_HOLD    (HOLD),
        .BLANK_CYCLES(BLK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .redpixels  (red_img),
        .grnpixels  (grn_img),
        .row_sel    (row_sel),
        .red_drv    (red_drv),
        .grn_drv    (grn_drv),
        .row_idx    (row_idx),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Model state: position in frame (-1 = idle) and latched images
    int                pos = -1;
    logic [15:0][15:0] m_red = '0;
    logic [15:0][15:0] m_grn = '0;

    // Apply inputs for the next edge, predict the outputs after it
    task automatic step(input logic r, input logic en);
        exp_t e;
        int   row;
        int   ph;
        reset  = r;
        enable = en;
        e = '0;
        if (!r) begin
            pos   = -1;
            m_red = '0;
            m_grn = '0;
        end else if (!en) begin
            pos = -1;
        end else begin
            pos = (pos < 0) ? 0 : (pos + 1) % PERIOD;
            if (pos == 0) begin
                m_red = red_img;
                m_grn = grn_img;
            end
            row  = pos / SLOT;
            ph   = pos % SLOT;
            e.ri = row[3:0];
            e.fs = (pos == 0);
            if (ph >= GAP) begin
                e.rs = 16'd1 << row;
                e.rd = m_red[row];
                e.gd = m_grn[row];
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one output word per cycle, compared on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (row_sel !== e.rs || red_drv !== e.rd || grn_drv !== e.gd ||
                row_idx !== e.ri || frame_start !== e.fs) begin
                miscompares++;
                $display("FAIL cycle_outputs t=%0t: got row_sel=%h red=%h grn=%h idx=%0d fs=%b, expected row_sel=%h red=%h grn=%h idx=%0d fs=%b",
                         $time, row_sel, red_drv, grn_drv, row_idx, frame_start,
                         e.rs, e.rd, e.gd, e.ri, e.fs);
            end
        end
    end

    task automatic seek_row7(input string name);
        bit found = 0;
        for (int k = 0; k < 2 * PERIOD && !found; k++) begin
            if (pos >= 0 && pos / SLOT == 7 && pos % SLOT == GAP + 1) found = 1;
            else step(1'b1, 1'b1);
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL %s: row 7 drive not reached within %0d cycles, required reached", name, 2 * PERIOD);
        end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin
            red_img[r] = 16'($urandom);
            grn_img[r] = 16'($urandom);
        end
        red_img[0] = 16'h0001;
        grn_img[0] = 16'h8000;

        // Reset held with enable high
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Two-plus frames; row 5 red changes while row 2 is active
        for (int i = 0; i < 2 * PERIOD + 10; i++) begin
            if (i == 2 * SLOT + 1) red_img[5] = 16'hFFFF;
            step(1'b1, 1'b1);
        end

        // Disable during row 7, then re-enable
        seek_row7("seek_disable");
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < SLOT * 3; i++) step(1'b1, 1'b1);

        // Reset during row 7, then release
        seek_row7("seek_reset");
        step(1'b0, 1'b1);
        for (int i = 0; i < SLOT * 3; i++) step(1'b1, 1'b1);

        // Randomized run: image churn, occasional disable and reset
        for (int i = 0; i < 2500; i++) begin
            int sel;
            if ($urandom_range(7) == 0) begin
                sel = $urandom_range(15);
                red_img[sel] = 16'($urandom);
                grn_img[sel] = 16'($urandom);
            end
            step(($urandom_range(299) != 0), ($urandom_range(199) != 0));
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected words left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
